// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Start/Busy/Done handshake; MTHI/MTLO writes are accepted only while idle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWre,
  input  logic             LoWre,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      count;
  logic               opDiv, negRes, negRem, divZero, doneReg;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;

  logic               isDiv, isSigned, signA, signB;
  logic [WIDTH-1:0]   absA, absB, quo, rem, quoFix, remFix;
  logic [WIDTH:0]     mulSum, divTrial;
  logic [2*WIDTH-1:0] prodFix;

  assign Busy = (state != IDLE);
  assign Done = doneReg;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (Start) stateNext = CALC;
      CALC:    if (count == LAST) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    isDiv    = Op[1];
    isSigned = Op[0];
    signA    = isSigned & SrcA[WIDTH-1];
    signB    = isSigned & SrcB[WIDTH-1];
    absA     = signA ? -SrcA : SrcA;
    absB     = signB ? -SrcB : SrcB;
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    prodFix  = negRes ? -acc : acc;
    // A zero divisor leaves the dividend magnitude as remainder, so the
    // remainder sign fix-up alone restores the original SrcA into HI.
    quoFix   = divZero ? '1 : (negRes ? -quo : quo);
    remFix   = negRem ? -rem : rem;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count   <= '0;
      opDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      operand <= '0;
      acc     <= '0;
      HI      <= '0;
      LO      <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FINISH);
      unique case (state)
        IDLE: begin
          if (Start) begin
            count   <= '0;
            opDiv   <= isDiv;
            negRes  <= signA ^ signB;
            negRem  <= isDiv & signA;
            divZero <= isDiv & (SrcB == '0);
            operand <= isDiv ? absB : absA;
            acc     <= {{WIDTH{1'b0}}, (isDiv ? absA : absB)};
          end else begin
            if (HiWre) HI <= WriteData;
            if (LoWre) LO <= WriteData;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (opDiv) begin
            if (!divTrial[WIDTH]) acc <= {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mulSum, acc[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (opDiv) begin
            HI <= remFix;
            LO <= quoFix;
          end else begin
            HI <= prodFix[2*WIDTH-1:WIDTH];
            LO <= prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: products, quotients,
// divide-by-zero/overflow corners, MTHI/MTLO and handshake/reset behaviour.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        Reset, Start, HiWre, LoWre;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WriteData;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int n, doneSeen;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWre(HiWre), .LoWre(LoWre), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion. injectAt > 0 pulses
  // Start+HiWre during that busy cycle; wrIdle raises HiWre with Start.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input int injectAt, input bit wrIdle);
    logic [31:0] hiB, loB;
    int busyCycles;
    hiB = HI;
    loB = LO;
    @(negedge CLK);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    HiWre = wrIdle; WriteData = 32'd5;
    @(negedge CLK);
    Start = 1'b0; HiWre = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
    busyCycles = 0;
    while (Busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      if (busyCycles == 16) begin
        check({tag, " midHI"}, HI, hiB);
        check({tag, " midLO"}, LO, loB);
      end
      if (busyCycles == injectAt) begin
        Start = 1'b1; HiWre = 1'b1; WriteData = 32'd5;
      end else begin
        Start = 1'b0; HiWre = 1'b0;
      end
      @(negedge CLK);
    end
    Start = 1'b0; HiWre = 1'b0;
    check({tag, " busyCycles"}, 32'(busyCycles), 32'd33);
    check({tag, " Done"}, {31'd0, Done}, 32'd1);
    check({tag, " HI"}, HI, expHi);
    check({tag, " LO"}, LO, expLo);
    @(negedge CLK);
    check({tag, " DoneOff"}, {31'd0, Done}, 32'd0);
    check({tag, " BusyOff"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
    Op = 2'b00; SrcA = '0; SrcB = '0; WriteData = '0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check("rst HI", HI, 32'h0);
    check("rst LO", LO, 32'h0);
    check("rst Busy", {31'd0, Busy}, 32'd0);
    check("rst Done", {31'd0, Done}, 32'd0);

    runOp("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
    runOp("mult -3*7", MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1'b0);
    runOp("div -7/2",  DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
    runOp("div 7/-2",  DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0);
    runOp("divu 100/7", DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       0, 1'b0);
    runOp("divu /0",   DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 0, 1'b0);
    runOp("div -7/0",  DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0, 1'b0);
    runOp("div ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
    runOp("mult minsq", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 1'b0);
    // Start+HiWre together in idle (write dropped), then Start+HiWre mid-run (ignored)
    runOp("multu 6x7", MULTU, 32'd6,        32'd7,        32'h0,        32'd42,       10, 1'b1);

    @(negedge CLK);
    HiWre = 1'b1; LoWre = 1'b1; WriteData = 32'h55;
    @(negedge CLK);
    HiWre = 1'b0; LoWre = 1'b0;
    check("mt both HI", HI, 32'h55);
    check("mt both LO", LO, 32'h55);
    LoWre = 1'b1; WriteData = 32'hABCD;
    @(negedge CLK);
    LoWre = 1'b0;
    check("mtlo LO", LO, 32'hABCD);
    check("mtlo HI", HI, 32'h55);

    Start = 1'b1; Op = DIVU; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    n = 1;
    while (n < 15) begin
      @(negedge CLK);
      n++;
    end
    check("pre-rst Busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    #1;
    check("arst Busy", {31'd0, Busy}, 32'd0);
    check("arst HI", HI, 32'h0);
    check("arst LO", LO, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done === 1'b1) doneSeen++;
    end
    check("arst no Done", 32'(doneSeen), 32'd0);
    check("arst idle", {31'd0, Busy}, 32'd0);
    check("arst HI hold", HI, 32'h0);

    runOp("divu after rst", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
